gsensor_spi_reader: RTL and testbench
=====================================

// Module: gsensor_spi_reader
// PURPOSE
//  SPI master for the on-board ADXL345 accelerometer (4-wire, SPI mode 3).
//  After reset it configures the sensor once, then reads X/Y periodically.
//  It publishes signed 8-bit tilt samples sdata_x/sdata_y to the seven-segment display controller.
// PARAMETERS
//  CLK_DIV        25      clk cycles per SCLK half-period (50 MHz -> 1 MHz SCLK); min 2
//  SAMPLE_PERIOD  500000  clk cycles between read starts (100 Hz); must exceed 100*CLK_DIV
// PORTS
//  clk         in   1  system clock, 50 MHz
//  rst_n       in   1  asynchronous active-low reset
//  gs_cs_n     out  1  sensor chip select, active low
//  gs_sclk     out  1  SPI clock, idles high
//  gs_sdi      out  1  MOSI to sensor
//  gs_sdo      in   1  MISO from sensor
//  sdata_x     out  8  X sample = {DATAX1[1:0],DATAX0[7:2]}, two's complement
//  sdata_y     out  8  Y sample = {DATAY1[1:0],DATAY0[7:2]}, two's complement
//  data_valid  out  1  1-cycle pulse when sdata_x/sdata_y update
//  init_done   out  1  high once configuration writes complete; stays high until reset
// BEHAVIOUR
//  Reset values: gs_cs_n=1, gs_sclk=1, gs_sdi=0, sdata_x=0, sdata_y=0, data_valid=0, init_done=0; FSM in S_IDLE.
//  Reset is async and can arrive mid-transaction.
//  - All outputs take their reset values immediately.
//  - CS_N goes high at once.
//  - The full init sequence reruns after rst_n rises.
//  FSM states and transitions:
//  - S_IDLE: one cycle after reset -> S_WR_FMT.
//  - S_WR_FMT: write DATA_FORMAT 0x31 = 0x00 (4-wire, 10-bit, +/-2g) -> S_WR_PWR.
//  - S_WR_PWR: write POWER_CTL 0x2D = 0x08 (measure) -> S_WAIT; init_done set when this transfer ends.
//  - S_WAIT: wait for the sample timer to expire -> S_READ.
//  - S_READ: burst read of 4 bytes from 0x32 -> S_UPDATE.
//  - S_UPDATE: one cycle; load sdata_x/sdata_y and pulse data_valid -> S_WAIT.
//  Write transfer: 16 SCLK periods; command byte {R=0, MB=0, addr[5:0]}, then the data byte.
//  Read transfer: 40 SCLK periods; command 0xF2 {R=1, MB=1, 0x32}, then 4 bytes received: X0, X1, Y0, Y1.
//  Transfer timing, every transfer:
//  - CS_N falls; SCLK stays high for CLK_DIV cycles (setup).
//  - Then N periods of CLK_DIV low + CLK_DIV high.
//  - MOSI changes only on SCLK falling edges, MSB first.
//  - MISO is sampled on SCLK rising edges, MSB first.
//  - After the last rising edge, SCLK stays high for CLK_DIV cycles, then CS_N rises.
//  - CS_N holds high at least CLK_DIV cycles before the next transfer.
//  MOSI is driven 0 during the data phase of reads and whenever CS_N is high.
//  Sample timer:
//  - Loads SAMPLE_PERIOD-1 on entry to S_READ and counts down to 0.
//  - Read starts are therefore exactly SAMPLE_PERIOD clk cycles apart.
//  - The first read starts CLK_DIV cycles after the S_WR_PWR CS_N rise.
//  Update rules:
//  - sdata_x and sdata_y update together, on the cycle data_valid is high, and hold between updates.
//  - Partial data from an interrupted transfer is never published.
//  Width rule: the 10-bit sign bit (DATAx1[1]) becomes bit 7 of the output; DATAx1[7:2] are ignored.
//  SCLK counting uses a bit counter of 6 bits, sufficient for 40 periods; there is no wrap within a transfer.
// TESTING (bench has an ADXL345 SPI-slave model, mode 3)
//  1. Release reset -> exactly two write transfers, in order: MOSI bytes 0x31,0x00 then 0x2D,0x08.
//     init_done rises at the end of the second transfer.
//  2. Model returns X0=0xFC X1=0x03 Y0=0x08 Y1=0x00 -> sdata_x=0xFF, sdata_y=0x02.
//     data_valid is high for 1 cycle; command byte on MOSI = 0xF2.
//  3. Model returns X0=0x00 X1=0x02 Y0=0xFF Y1=0x01 -> sdata_x=0x80, sdata_y=0x7F (sign extremes).
//  4. Check SCLK timing with CLK_DIV=25:
//     - SCLK period = 50 cycles; read transfer has 40 rising edges.
//     - CS_N low-to-first-fall = 25 cycles; no MOSI change while SCLK is high.
//  5. Run 3 reads with SAMPLE_PERIOD=10000 -> CS_N falling edges of consecutive reads are 10000 cycles apart.
//  6. Assert rst_n low at the 20th SCLK of a read -> CS_N=1, SCLK=1, sdata_x/sdata_y=0 immediately.
//     On release, the init writes repeat; the aborted read produces no data_valid.

Source files
------------

// File: rtl/gsensor_spi_reader.sv
// ADXL345 accelerometer reader: 4-wire SPI master in mode 3.
// After reset it writes DATA_FORMAT and POWER_CTL once. It then burst-reads
// X0/X1/Y0/Y1 every SAMPLE_PERIOD cycles and publishes the top 8 bits of the
// 10-bit X and Y readings as signed tilt samples.
module gsensor_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       gs_cs_n,
  output logic       gs_sclk,
  output logic       gs_sdi,
  input  logic       gs_sdo,
  output logic [7:0] sdata_x,
  output logic [7:0] sdata_y,
  output logic       data_valid,
  output logic       init_done
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [TW-1:0] PER_LOAD = TW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [5:0]    WR_LAST  = 6'd15;  // 16 SCLK periods per write
  localparam logic [5:0]    RD_LAST  = 6'd39;  // 40 SCLK periods per read

  // Command/data words shifted out MSB first.
  localparam logic [15:0] TX_FMT  = 16'h3100;  // DATA_FORMAT <= 0x00
  localparam logic [15:0] TX_PWR  = 16'h2D08;  // POWER_CTL   <= 0x08
  localparam logic [15:0] TX_READ = 16'hF200;  // read, multi-byte, from 0x32

  typedef enum logic [2:0] {
    S_IDLE, S_WR_FMT, S_WR_PWR, S_WAIT, S_READ, S_UPDATE
  } state_t;

  // Phases of a single transfer. X_GAP keeps CS_N high before a write so the
  // sensor always sees a deselect interval between back-to-back transfers.
  typedef enum logic [1:0] {
    X_GAP, X_SETUP, X_LOW, X_HIGH
  } xphase_t;

  state_t        state_q, state_d;
  xphase_t       xph_q, xph_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          sdi_q, sdi_d;
  logic [7:0]    sx_q, sx_d;
  logic [7:0]    sy_q, sy_d;
  logic          dv_q, dv_d;
  logic          init_q, init_d;

  logic          is_xfer;
  logic [5:0]    last_bit;
  logic          xfer_done;

  assign is_xfer  = (state_q == S_WR_FMT) || (state_q == S_WR_PWR) || (state_q == S_READ);
  assign last_bit = (state_q == S_READ) ? RD_LAST : WR_LAST;

  assign gs_cs_n    = cs_n_q;
  assign gs_sclk    = sclk_q;
  assign gs_sdi     = sdi_q;
  assign sdata_x    = sx_q;
  assign sdata_y    = sy_q;
  assign data_valid = dv_q;
  assign init_done  = init_q;

  // Next state: SPI bit engine first, then the sequencing FSM overrides it.
  always_comb begin
    state_d   = state_q;
    xph_d     = xph_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    timer_d   = (timer_q != '0) ? (timer_q - TMR_ONE) : timer_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dv_d      = 1'b0;
    init_d    = init_q;
    xfer_done = 1'b0;

    if (is_xfer) begin
      // Every phase lasts exactly CLK_DIV cycles; act on the last one.
      div_d = (div_q != '0) ? (div_q - DIV_ONE) : DIV_LOAD;
      if (div_q == '0) begin
        case (xph_q)
          X_GAP: begin
            cs_n_d = 1'b0;
            xph_d  = X_SETUP;
          end
          X_SETUP: begin
            sclk_d = 1'b0;
            sdi_d  = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
            xph_d  = X_LOW;
          end
          X_LOW: begin
            // Rising SCLK edge: sensor data has been stable since the fall.
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], gs_sdo};
            xph_d  = X_HIGH;
          end
          X_HIGH: begin
            if (bit_q == last_bit) begin
              cs_n_d    = 1'b1;
              sdi_d     = 1'b0;
              xfer_done = 1'b1;
            end else begin
              sclk_d = 1'b0;
              sdi_d  = tx_q[15];
              tx_d   = {tx_q[14:0], 1'b0};
              bit_d  = bit_q + 6'd1;
              xph_d  = X_LOW;
            end
          end
          default: xph_d = X_GAP;
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_WR_FMT;
        xph_d   = X_GAP;
        div_d   = DIV_LOAD;
        bit_d   = '0;
        tx_d    = TX_FMT;
      end
      S_WR_FMT: begin
        if (xfer_done) begin
          state_d = S_WR_PWR;
          xph_d   = X_GAP;
          div_d   = DIV_LOAD;
          bit_d   = '0;
          tx_d    = TX_PWR;
        end
      end
      S_WR_PWR: begin
        if (xfer_done) begin
          // Timer doubles as the CS_N-high gap before the first read.
          state_d = S_WAIT;
          init_d  = 1'b1;
          timer_d = GAP_LOAD;
        end
      end
      S_WAIT: begin
        if (timer_q == '0) begin
          // Read starts directly with CS_N low; the period timer restarts here.
          state_d = S_READ;
          cs_n_d  = 1'b0;
          xph_d   = X_SETUP;
          div_d   = DIV_LOAD;
          bit_d   = '0;
          tx_d    = TX_READ;
          timer_d = PER_LOAD;
        end
      end
      S_READ: begin
        if (xfer_done) begin
          // rx_q = {X0, X1, Y0, Y1}; keep sign bit DATAx1[1] as output bit 7.
          state_d = S_UPDATE;
          sx_d    = {rx_q[17:16], rx_q[31:26]};
          sy_d    = {rx_q[1:0], rx_q[15:10]};
          dv_d    = 1'b1;
        end
      end
      S_UPDATE: state_d = S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset that deselects the sensor at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      xph_q   <= X_GAP;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      timer_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      sdi_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      dv_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xph_q   <= xph_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      timer_q <= timer_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      dv_q    <= dv_d;
      init_q  <= init_d;
    end
  end

endmodule

// File: tb/tb_gsensor_spi_reader.sv
// Bench for gsensor_spi_reader: cycle-sampled ADXL345 mode-3 slave model,
// SPI timing monitor and sample scoreboard, all stepped on the falling clk edge.
module tb_gsensor_spi_reader;

  localparam int CLK_DIV       = 25;
  localparam int SAMPLE_PERIOD = 10000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gs_cs_n;
  logic       gs_sclk;
  logic       gs_sdi;
  logic       gs_sdo;
  logic [7:0] sdata_x;
  logic [7:0] sdata_y;
  logic       data_valid;
  logic       init_done;

  logic       sdo_r;
  assign gs_sdo = sdo_r;

  gsensor_spi_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gs_cs_n   (gs_cs_n),
    .gs_sclk   (gs_sclk),
    .gs_sdi    (gs_sdi),
    .gs_sdo    (gs_sdo),
    .sdata_x   (sdata_x),
    .sdata_y   (sdata_y),
    .data_valid(data_valid),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int          total;
  int          bad;
  int          cyc;
  int          guard;
  logic        prev_cs, prev_sclk, prev_sdi;
  int          run;           // samples SCLK has held its level inside a transfer
  int          cs_high_run;   // samples CS_N has been high since its last rise
  int          falls;         // CS_N falling edges since reset
  int          last_read_start;
  int          xact_n;        // completed transfers since reset
  int          rd_n;          // read patterns handed out (all time)
  int          pub_cnt;
  int          pub_epoch;
  int          s_rise, s_fall;
  logic [39:0] s_mosi;
  logic [31:0] s_miso;
  logic        s_isread;
  logic        init_exp;
  logic        pend;
  int          pend_dl;
  logic [7:0]  pend_x, pend_y, held_x, held_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sensor reading -> published tilt: signed 10-bit value divided by 4 (floor).
  function automatic logic [7:0] tilt(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'(hi[1:0]) * 256 + int'(lo);
    if (v >= 512) v = v - 1024;
    v = v >>> 2;
    return v[7:0];
  endfunction

  task automatic model_reset();
    prev_cs         = 1'b1;
    prev_sclk       = 1'b1;
    prev_sdi        = 1'b0;
    run             = 0;
    cs_high_run     = 0;
    falls           = 0;
    last_read_start = -1;
    xact_n          = 0;
    pub_epoch       = 0;
    s_rise          = 0;
    s_fall          = 0;
    s_mosi          = '0;
    s_miso          = '0;
    s_isread        = 1'b0;
    sdo_r           = 1'b0;
    init_exp        = 1'b0;
    pend            = 1'b0;
    pend_dl         = 0;
    pend_x          = '0;
    pend_y          = '0;
    held_x          = '0;
    held_y          = '0;
  endtask

  task automatic step();
    logic        cs_fell, cs_rose;
    logic [39:0] exp_mosi;
    int          exp_bits;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs",
          64'({gs_cs_n, gs_sclk, gs_sdi, data_valid, init_done, sdata_x, sdata_y}),
          64'({5'b11000, 16'h0000}));
      model_reset();
      return;
    end
    cs_fell = prev_cs && !gs_cs_n;
    cs_rose = !prev_cs && gs_cs_n;
    if (cs_fell) begin
      if (falls == 2) chk("first_read_gap", 64'(cs_high_run), 64'(CLK_DIV));
      else            chk("cs_high_gap", 64'(cs_high_run >= CLK_DIV), 64'(1));
      chk("cs_fall_lines", 64'({gs_sclk, gs_sdi}), 64'(2'b10));
      falls++;
      if (falls >= 3) begin
        if (last_read_start >= 0)
          chk("read_spacing", 64'(cyc - last_read_start), 64'(SAMPLE_PERIOD));
        last_read_start = cyc;
      end
      run      = 1;
      s_rise   = 0;
      s_fall   = 0;
      s_mosi   = '0;
      s_miso   = '0;
      s_isread = 1'b0;
      sdo_r    = 1'b0;
    end else if (!gs_cs_n) begin
      chk("mosi_only_on_fall",
          64'((gs_sdi == prev_sdi) || (prev_sclk && !gs_sclk)), 64'(1));
      if (gs_sclk != prev_sclk) begin
        chk("sclk_half_period", 64'(run), 64'(CLK_DIV));
        run = 1;
        if (!gs_sclk) begin
          // Slave: after 8 command bits decide whether this is a burst read.
          if (s_fall == 8 && s_mosi[7:6] == 2'b11) begin
            s_isread = 1'b1;
            if (rd_n == 0)      s_miso = 32'hFC03_0800;
            else if (rd_n == 1) s_miso = 32'h0002_FF01;
            else                s_miso = $urandom();
            rd_n++;
          end
          if (s_isread && s_fall >= 8 && s_fall < 40) sdo_r = s_miso[39 - s_fall];
          s_fall++;
        end else begin
          s_mosi = {s_mosi[38:0], gs_sdi};
          s_rise++;
        end
      end else begin
        run++;
      end
    end else if (cs_rose) begin
      chk("sclk_hold_before_cs_rise", 64'(run), 64'(CLK_DIV));
      chk("cs_rise_lines", 64'({gs_sclk, gs_sdi}), 64'(2'b10));
      cs_high_run = 1;
      exp_bits = (xact_n < 2) ? 16 : 40;
      exp_mosi = (xact_n == 0) ? 40'h00_0000_3100 :
                 (xact_n == 1) ? 40'h00_0000_2D08 : 40'hF2_0000_0000;
      $display("xact %0d: sclk_periods=%0d mosi=%010h miso=%08h", xact_n, s_rise, s_mosi, s_miso);
      chk("xact_sclk_periods", 64'(s_rise), 64'(exp_bits));
      chk("xact_mosi", 64'(s_mosi), 64'(exp_mosi));
      if (xact_n == 1) init_exp = 1'b1;
      if (xact_n >= 2 && s_isread && s_rise == 40) begin
        pend    = 1'b1;
        pend_x  = tilt(s_miso[31:24], s_miso[23:16]);
        pend_y  = tilt(s_miso[15:8], s_miso[7:0]);
        pend_dl = cyc + 3;
      end
      xact_n++;
    end else begin
      cs_high_run++;
      chk("idle_lines", 64'({gs_sclk, gs_sdi}), 64'(2'b10));
    end
    prev_cs   = gs_cs_n;
    prev_sclk = gs_sclk;
    prev_sdi  = gs_sdi;

    chk("init_done", 64'(init_done), 64'(init_exp));
    if (data_valid) begin
      chk("data_valid_expected", 64'(pend), 64'(1));
      if (pend) begin
        $display("sample %0d: x=%02h y=%02h", pub_cnt, sdata_x, sdata_y);
        chk("sdata_new", 64'({sdata_x, sdata_y}), 64'({pend_x, pend_y}));
        if (pub_cnt == 0) chk("sdata_pattern_a", 64'({sdata_x, sdata_y}), 64'(16'hFF02));
        if (pub_cnt == 1) chk("sdata_sign_extremes", 64'({sdata_x, sdata_y}), 64'(16'h807F));
        held_x = pend_x;
        held_y = pend_y;
        pend   = 1'b0;
        pub_cnt++;
        pub_epoch++;
      end
    end else begin
      chk("sdata_hold", 64'({sdata_x, sdata_y}), 64'({held_x, held_y}));
      if (pend && cyc > pend_dl) begin
        chk("data_valid_latency", 64'(data_valid), 64'(1));
        pend = 1'b0;
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    rd_n    = 0;
    pub_cnt = 0;
    guard   = 0;
    rst_n   = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk("reset_initial",
           64'({gs_cs_n, gs_sclk, gs_sdi, data_valid, init_done, sdata_x, sdata_y}),
           64'({5'b11000, 16'h0000}));
    repeat (3) begin
      @(negedge clk);
      step();
    end
    #2 rst_n = 1'b1;

    // Init writes, then three published reads; stop at SCLK 20 of the fourth.
    while (!(rd_n == 4 && s_fall >= 20) && guard < 40000) begin
      @(negedge clk);
      step();
      guard++;
    end
    chk("reads_before_abort", 64'(rd_n), 64'(4));
    chk("abort_at_sclk", 64'(s_fall), 64'(20));
    chk("pubs_before_abort", 64'(pub_cnt), 64'(3));

    #2 rst_n = 1'b0;
    #1 chk("reset_mid_read",
           64'({gs_cs_n, gs_sclk, gs_sdi, data_valid, init_done, sdata_x, sdata_y}),
           64'({5'b11000, 16'h0000}));
    repeat (4) begin
      @(negedge clk);
      step();
    end
    #2 rst_n = 1'b1;

    guard = 0;
    while (pub_epoch < 3 && guard < 30000) begin
      @(negedge clk);
      step();
      guard++;
    end
    chk("pubs_after_reset", 64'(pub_epoch), 64'(3));
    chk("xacts_after_reset", 64'(xact_n), 64'(5));
    chk("pubs_total", 64'(pub_cnt), 64'(6));
    repeat (20) begin
      @(negedge clk);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
